// File: rtl/frame_line_sequencer.sv
// Frame-level sequencer in front of the line-buffer window generator.
// Meters one frame of pixels into the generator. The generator's
// line-read-complete pulse frees a line buffer. After the last useful
// window row is read, the generator gets a one-cycle reset.
//
// Handshake: an upstream beat transfers on a cycle where
// i_pixel_data_valid && o_pixel_ready are both high. o_pixel_ready depends
// only on registered state, never on i_pixel_data_valid. Downstream has no
// backpressure: o_pixel_data_valid marks each forwarded pixel, which arrives
// one cycle after its upstream beat.
module frame_line_sequencer #(
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 480,
  parameter int LB_DEPTH   = 7,
  parameter int WIN        = 6,
  localparam int RW = $clog2(IMG_HEIGHT + 1),
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  localparam int HW = $clog2(LB_DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_frame_done,
  input  logic [7:0]    i_pixel_data,
  input  logic          i_pixel_data_valid,
  output logic          o_pixel_ready,
  output logic [7:0]    o_pixel_data,
  output logic          o_pixel_data_valid,
  input  logic          i_dp_intr,
  output logic          o_dp_rst,
  output logic [RW-1:0] o_in_row,
  output logic [RW-1:0] o_out_row,
  output logic          o_err,
  output logic [1:0]    o_state,
  output logic [HW-1:0] o_lines_held
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] OUT_LAST = RW'(IMG_HEIGHT - WIN + 1);
  localparam logic [HW-1:0] HELD_MAX = HW'(LB_DEPTH);
  localparam logic [HW-1:0] HELD_WIN = HW'(WIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   col_cnt;
  logic [HW-1:0]   lines_held;
  logic            flush_pulse;
  logic            beat;
  logic            line_done;
  logic            intr_ok;
  logic            intr_err;

  assign beat      = i_pixel_data_valid & o_pixel_ready;
  assign line_done = beat & (col_cnt == COL_LAST);
  // A read completion is only legitimate once a full window of lines is held.
  assign intr_ok   = i_dp_intr & (state != S_IDLE) & (lines_held >= HELD_WIN);
  assign intr_err  = i_dp_intr & ((state == S_IDLE) | (lines_held < HELD_WIN));

  assign o_frame_done = flush_pulse;
  assign o_dp_rst     = i_rst | flush_pulse;
  assign o_state      = state;
  assign o_lines_held = lines_held;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: fill until the last line lands, drain until the last
  // useful window row is read, then one flush cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_FILL;
      S_FILL:  if (line_done && (o_in_row == ROW_LAST)) state_nxt = S_DRAIN;
      S_DRAIN: if (o_out_row == OUT_LAST) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: ready only while filling with a free line buffer.
  always_comb begin
    o_pixel_ready = 1'b0;
    flush_pulse   = 1'b0;
    case (state)
      S_FILL:  o_pixel_ready = (lines_held < HELD_MAX);
      S_FLUSH: flush_pulse   = 1'b1;
      default: ;
    endcase
  end

  // Pixel forwarding, row/column counters, line credit and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy             <= 1'b0;
      o_err              <= 1'b0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_in_row           <= '0;
      o_out_row          <= '0;
      col_cnt            <= '0;
      lines_held         <= '0;
    end else begin
      o_pixel_data_valid <= beat;
      if (beat) o_pixel_data <= i_pixel_data;

      if ((state == S_IDLE) && i_start) begin
        col_cnt    <= '0;
        lines_held <= '0;
        o_in_row   <= '0;
        o_out_row  <= '0;
        o_err      <= 1'b0;
        o_busy     <= 1'b1;
      end else begin
        if (beat)      col_cnt  <= line_done ? '0 : col_cnt + 1'b1;
        if (line_done) o_in_row <= o_in_row + 1'b1;
        if (intr_ok)   o_out_row <= o_out_row + 1'b1;
        case ({line_done, intr_ok})
          2'b10:   lines_held <= lines_held + 1'b1;
          2'b01:   lines_held <= lines_held - 1'b1;
          default: ;
        endcase
        if (intr_err) o_err <= 1'b1;
        if (state == S_FLUSH) o_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_line_sequencer.sv
// Bench for frame_line_sequencer on a small 8x10 frame.
// A count-based reference model tracks accepted beats and legitimate reads.
// A scoreboard queue checks forwarded pixel order.
// Directed scenarios cover reset, full frames, credit stall, coincident
// line/read, error flag and mid-frame reset.
module tb_frame_line_sequencer;

  localparam int W  = 8;
  localparam int H  = 10;
  localparam int LB = 7;
  localparam int WN = 6;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_pixel_data = '0;
  logic       i_pixel_data_valid = 1'b0;
  logic       man_intr = 1'b0;
  logic       auto_intr = 1'b0;
  logic       i_dp_intr;
  logic       o_busy, o_frame_done, o_pixel_ready, o_pixel_data_valid;
  logic       o_dp_rst, o_err;
  logic [7:0] o_pixel_data;
  logic [3:0] o_in_row, o_out_row;
  logic [1:0] o_state;
  logic [2:0] o_lines_held;

  assign i_dp_intr = man_intr | auto_intr;

  frame_line_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .LB_DEPTH(LB), .WIN(WN)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .i_pixel_data(i_pixel_data),
    .i_pixel_data_valid(i_pixel_data_valid), .o_pixel_ready(o_pixel_ready),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .i_dp_intr(i_dp_intr), .o_dp_rst(o_dp_rst), .o_in_row(o_in_row),
    .o_out_row(o_out_row), .o_err(o_err), .o_state(o_state),
    .o_lines_held(o_lines_held)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int done_rst_cnt = 0;
  int dl = 0;
  int iss = 0;
  int gap = 0;
  bit auto_en = 1'b0;
  logic [7:0] pix_next = 8'h11;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame progress is just "beats accepted" and "legitimate reads".
  // Lines held = completed lines minus reads.
  bit         m_busy = 1'b0;
  bit         m_flush = 1'b0;
  bit         m_err = 1'b0;
  bit         m_out_valid = 1'b0;
  logic [7:0] m_out_data = '0;
  int         m_acc = 0;
  int         m_rd = 0;

  function automatic bit model_ready();
    return m_busy && !m_flush && (m_acc < W * H) && ((m_acc / W - m_rd) < LB);
  endfunction

  always @(posedge clk) begin : model
    bit beat, drain, busy_old;
    int held, rd_old;
    held     = m_acc / W - m_rd;
    rd_old   = m_rd;
    busy_old = m_busy;
    drain    = m_busy && !m_flush && (m_acc == W * H);
    if (i_rst) begin
      m_busy = 0; m_flush = 0; m_err = 0; m_out_valid = 0; m_out_data = '0;
      m_acc = 0; m_rd = 0;
      exp_q.delete();
    end else begin
      beat = i_pixel_data_valid && model_ready();
      m_out_valid = beat;
      if (beat) begin
        m_out_data = i_pixel_data;
        exp_q.push_back(i_pixel_data);
      end
      if (i_dp_intr) begin
        if (!m_busy || held < WN) m_err = 1;
        else m_rd++;
      end
      if (m_flush) begin
        m_busy = 0; m_flush = 0;
      end else if (drain && rd_old == H - WN + 1) begin
        m_flush = 1;
      end
      if (!busy_old && i_start) begin
        m_busy = 1; m_acc = 0; m_rd = 0; m_err = 0;
      end
      if (beat) m_acc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [7:0] e;
    check("busy", o_busy, m_busy);
    check("ready", o_pixel_ready, model_ready());
    check("frame_done", o_frame_done, m_flush);
    check("dp_rst", o_dp_rst, i_rst | m_flush);
    check("in_row", o_in_row, m_acc / W);
    check("out_row", o_out_row, m_rd);
    check("lines_held", o_lines_held, m_acc / W - m_rd);
    check("err", o_err, m_err);
    check("out_valid", o_pixel_data_valid, m_out_valid);
    if (m_out_valid) check("out_data", o_pixel_data, m_out_data);
    if (o_pixel_data_valid === 1'b1) begin
      if (exp_q.size() == 0) check("pixel_order_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pixel_order", o_pixel_data, e);
      end
    end
  end

  // ---------------- done monitor ----------------
  always @(negedge clk) begin
    if (o_frame_done === 1'b1) begin
      done_cnt++;
      if (o_dp_rst === 1'b1) done_rst_cnt++;
    end
  end

  // ---------------- datapath model (read-complete generator) ----------------
  // Reads a window row once WIN delivered lines are unread, then takes a
  // few cycles before the next read.
  always @(negedge clk) begin
    if (i_rst || i_start) begin
      dl = 0; iss = 0; gap = 0; auto_intr = 1'b0;
    end else begin
      if (o_pixel_data_valid === 1'b1) dl++;
      if (auto_intr) begin
        auto_intr = 1'b0;
        gap = 3;
      end else if (gap > 0) begin
        gap--;
      end else if (auto_en && (dl / W - iss >= WN)) begin
        auto_intr = 1'b1;
        iss++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cycle_src(input bit v, output bit acc);
    i_pixel_data_valid = v;
    i_pixel_data = pix_next;
    @(negedge clk);
    acc = v && (o_pixel_ready === 1'b1);
    @(posedge clk); #1;
    if (acc) pix_next = pix_next + 8'd37;
  endtask

  task automatic send_beats(input int n, input int budget, output int got);
    int cyc;
    bit a;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      cycle_src(1'b1, a);
      if (a) got++;
      cyc++;
    end
    i_pixel_data_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int cyc;
    bit a;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      cycle_src(1'b1, a);
      cyc++;
    end
    i_pixel_data_valid = 1'b0;
    check("frame_done_in_budget", done_cnt != 0, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int got;
    bit a;

    // Reset held 3 cycles with valid high.
    i_pixel_data_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_dp_rst", o_dp_rst, 1);
      check("rst_ready", o_pixel_ready, 0);
      check("rst_valid", o_pixel_data_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_frame_done, 0);
      check("rst_err", o_err, 0);
      check("rst_rows", {o_in_row, o_out_row}, 0);
    end
    tick();
    i_rst = 1'b0;
    i_pixel_data_valid = 1'b0;
    tick();

    // Full frame, always-valid source, auto read-completes.
    auto_en = 1'b1;
    done_cnt = 0; done_rst_cnt = 0;
    pulse_start();
    run_until_done(2000);
    @(negedge clk);
    check("f1_forwarded", dl, 80);
    check("f1_in_row", o_in_row, 10);
    check("f1_out_row", o_out_row, 5);
    check("f1_model_rd", m_rd, 5);
    check("f1_done_pulses", done_cnt, 1);
    check("f1_done_with_dp_rst", done_rst_cnt, 1);
    check("f1_busy_after", o_busy, 0);
    check("f1_queue_empty", exp_q.size(), 0);
    tick();

    // Credit stall with read-completes withheld.
    auto_en = 1'b0;
    pulse_start();
    send_beats(56, 200, got);
    check("stall_beats_sent", got, 56);
    @(negedge clk);
    check("stall_ready", o_pixel_ready, 0);
    check("stall_held", o_lines_held, 7);
    check("stall_in_row", o_in_row, 7);
    tick();
    got = 0;
    repeat (4) begin
      cycle_src(1'b1, a);
      if (a) got++;
    end
    check("stall_no_accept", got, 0);
    man_intr = 1'b1;
    cycle_src(1'b1, a);
    man_intr = 1'b0;
    i_pixel_data_valid = 1'b0;
    check("ready_low_in_intr_cycle", a, 0);
    @(negedge clk);
    check("ready_after_intr", o_pixel_ready, 1);
    check("held_after_intr", o_lines_held, 6);
    tick();
    got = 0;
    repeat (20) begin
      cycle_src(1'b1, a);
      if (a) got++;
    end
    i_pixel_data_valid = 1'b0;
    check("beats_before_next_stall", got, 8);

    // Line completion coincident with a read-complete.
    man_intr = 1'b1;
    tick();
    man_intr = 1'b0;
    send_beats(7, 20, got);
    check("coinc_prefix", got, 7);
    man_intr = 1'b1;
    cycle_src(1'b1, a);
    man_intr = 1'b0;
    i_pixel_data_valid = 1'b0;
    check("coinc_beat_taken", a, 1);
    @(negedge clk);
    check("coinc_in_row", o_in_row, 9);
    check("coinc_out_row", o_out_row, 3);
    check("coinc_held", o_lines_held, 6);
    tick();

    // Start while filling is ignored.
    pulse_start();
    @(negedge clk);
    check("start_in_fill_busy", o_busy, 1);
    check("start_in_fill_state", o_state, 1);
    check("start_in_fill_in_row", o_in_row, 9);
    tick();

    // Finish the frame by hand: last line, then two reads.
    done_cnt = 0;
    send_beats(8, 20, got);
    check("last_line_beats", got, 8);
    repeat (2) begin
      man_intr = 1'b1;
      tick();
      man_intr = 1'b0;
      tick();
    end
    got = 0;
    while (done_cnt == 0 && got < 10) begin
      tick();
      got++;
    end
    check("f2_done_pulses", done_cnt, 1);
    check("f2_err", o_err, 0);
    tick();

    // Read-complete in idle sets the error; next start clears it.
    man_intr = 1'b1;
    tick();
    man_intr = 1'b0;
    @(negedge clk);
    check("idle_intr_err", o_err, 1);
    check("idle_intr_out_row", o_out_row, 5);
    tick();
    pulse_start();
    @(negedge clk);
    check("restart_err_clear", o_err, 0);
    check("restart_busy", o_busy, 1);
    check("restart_rows", {o_in_row, o_out_row}, 0);
    tick();

    // Mid-frame reset at four input rows, with a beat offered in that cycle.
    auto_en = 1'b1;
    send_beats(32, 100, got);
    @(negedge clk);
    check("mid_in_row", o_in_row, 4);
    tick();
    i_rst = 1'b1;
    i_pixel_data_valid = 1'b1;
    i_pixel_data = pix_next;
    @(negedge clk);
    check("mid_rst_dp_rst", o_dp_rst, 1);
    tick();
    i_rst = 1'b0;
    i_pixel_data_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_valid", o_pixel_data_valid, 0);
    check("mid_rst_rows", {o_in_row, o_out_row}, 0);
    check("mid_rst_held", o_lines_held, 0);
    check("mid_rst_ready", o_pixel_ready, 0);
    check("mid_rst_dp_rst_low", o_dp_rst, 0);
    tick();

    // Fresh frame after the reset completes normally.
    done_cnt = 0; done_rst_cnt = 0;
    pulse_start();
    run_until_done(2000);
    @(negedge clk);
    check("f3_forwarded", dl, 80);
    check("f3_out_row", o_out_row, 5);
    check("f3_in_row", o_in_row, 10);
    check("f3_done_pulses", done_cnt, 1);
    check("f3_busy_after", o_busy, 0);
    check("f3_queue_empty", exp_q.size(), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
